chunked_subtractor: RTL
=======================

# chunked_subtractor

Multi-cycle, parametrised successor to the lab's combinational full subtractor. It subtracts two WIDTH-bit operands with a borrow-in, processing CHUNK bits per clock LSB-first through a ripple of full-subtractor cells and a registered borrow between chunks. It uses a start/busy/done handshake and returns the difference, borrow-out, signed-overflow and zero flags. It serves as the arithmetic unit for the lab's sequential datapath exercises, where area is traded for cycles.

## Interface
- WIDTH, 8, operand and result width in bits; must be ≥ 1.
- CHUNK, 2, bits processed per cycle; must divide WIDTH exactly (1 ≤ CHUNK ≤ WIDTH).
- Derived: N = WIDTH/CHUNK, the number of processing cycles.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only while idle (busy=0).
- a  in  WIDTH  minuend; sampled with start.
- b  in  WIDTH  subtrahend; sampled with start.
- bin  in  1  borrow-in; sampled with start.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse; results are valid and updated in this cycle.
- diff  out  WIDTH  a − b − bin, modulo 2^WIDTH.
- bout  out  1  final borrow; 1 iff unsigned a < b + bin.
- ovf  out  1  signed (two's-complement) overflow.
- zero  out  1  diff == 0.

## Operation
- States:
  - IDLE: busy=0.
  - RUN: busy=1, with a chunk index k counting 0..N-1.
- IDLE → RUN: start=1 at a rising edge. a, b and bin are loaded into internal shift registers, and the borrow register is set to bin. k=0.
- RUN, each edge:
  - Chunk k is computed as CHUNK chained full-subtractor cells: d = x^y^br, br' = (~x&y) | (~(x^y)&br).
  - The chunk difference is shifted into the result register.
  - The borrow register is updated.
  - k increments.
- RUN → IDLE: at the edge where k = N-1 is processed. On that edge:
  - diff, bout, ovf and zero are written.
  - done goes to 1 for exactly one cycle.
- Output rules:
  - Output registers hold their values until the next done. diff does not show partial results.
  - ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]), using the captured operands. bin does not enter the ovf formula.
- Start handling:
  - start while busy=1 is ignored: it is neither queued nor allowed to corrupt the operation.
  - start in the done cycle (busy=0) is accepted, so back-to-back operations are supported.
- Operand stability: a, b and bin may change freely after the capture edge.
- rst at any time, including mid-operation:
  - state returns to IDLE and the operation is aborted; no done is produced.
  - busy=0, done=0, diff=0, bout=0, ovf=0, zero=0, and all internal registers are cleared.
  - Note: zero resets to 0, not 1.

## Timing
- Reset values: all outputs are 0.
- start is high in cycle 0 (captured at the end of cycle 0):
  - busy=1 in cycles 1..N.
  - done=1 and busy=0 in cycle N+1.
  - Latency from start to done is N+1 cycles, e.g. 5 for the defaults.
- Throughput is one operation per N+1 cycles when start is held high.
- With CHUNK=WIDTH (N=1), done arrives 2 cycles after start.
- With CHUNK=1 (N=WIDTH), the block is bit-serial.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
- Reset: assert rst mid-RUN (a=0x55, b=0x11, start pulsed, rst in cycle 2) → busy=0 immediately; no done ever pulses; all outputs 0.
- Defaults (8/2), a=0x05, b=0x03, bin=0 → cycle 5: done=1, diff=0x02, bout=0, ovf=0, zero=0.
- Borrow wrap: a=0x00, b=0x01, bin=0 → diff=0xFF, bout=1, ovf=0. Then a=0x07, b=0x06, bin=1 → diff=0x00, zero=1, bout=0.
- Signed overflow: a=0x80, b=0x01 → diff=0x7F, ovf=1, bout=0. Then a=0x7F, b=0xFF → diff=0x80, ovf=1, bout=1.
- Handshake: start held high continuously with new operands each done cycle → done every 5 cycles with matching results. A start pulse in cycle 2 of RUN with different operands → ignored; the first result is unchanged.
- Parameter sweep: (WIDTH, CHUNK) ∈ {(8,1), (8,8), (12,3), (3,1)}. Exhaustive a, b, bin for WIDTH=3 and random for the others, checked against a − b − bin. Latency is N+1 in every case.

Source files
------------

// File: rtl/chunked_subtractor.sv
// ---------------------------------------------------------------------------
// chunked_subtractor
//
// Multi-cycle subtractor that computes diff = a - b - bin (mod 2^WIDTH).
// Each clock it handles CHUNK bits, LSB first, through a ripple of
// full-subtractor cells. A registered borrow links one chunk to the next.
// A start/busy/done handshake controls it. An operation takes N = WIDTH/CHUNK
// processing cycles, and done pulses one cycle after the last of them.
//
// Parameters:
//   WIDTH  operand/result width in bits (>= 1)
//   CHUNK  bits processed per cycle; must divide WIDTH exactly
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-high reset (aborts any operation)
//   start  request; sampled only while idle (busy = 0)
//   a      minuend, captured with start
//   b      subtrahend, captured with start
//   bin    borrow-in, captured with start
//   busy   high while an operation is in progress
//   done   one-cycle pulse; the result outputs update in this cycle
//   diff   a - b - bin, modulo 2^WIDTH
//   bout   final borrow (1 iff unsigned a < b + bin)
//   ovf    two's-complement overflow of a - b
//   zero   diff == 0
// ---------------------------------------------------------------------------
module chunked_subtractor #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             br;
    logic [KW-1:0]    k;
    logic             a_msb;
    logic             b_msb;

    // Ripple of full-subtractor cells across the current low chunk.
    logic [CHUNK:0]   chain;
    logic [CHUNK-1:0] chunk_d;

    assign chain[0] = br;

    generate
        for (genvar gi = 0; gi < CHUNK; gi++) begin : g_cell
            logic x;
            logic y;
            assign x             = a_sh[gi];
            assign y             = b_sh[gi];
            assign chunk_d[gi]   = x ^ y ^ chain[gi];
            assign chain[gi + 1] = (~x & y) | (~(x ^ y) & chain[gi]);
        end
    endgenerate

    // Operands shift right by one chunk per cycle. Chunk results enter the
    // result register at the top, so after N cycles the result is in place.
    logic [WIDTH-1:0] a_next;
    logic [WIDTH-1:0] b_next;
    logic [WIDTH-1:0] res_next;

    generate
        if (CHUNK == WIDTH) begin : g_single
            assign a_next   = '0;
            assign b_next   = '0;
            assign res_next = chunk_d;
        end else begin : g_multi
            assign a_next   = {{CHUNK{1'b0}}, a_sh[WIDTH-1:CHUNK]};
            assign b_next   = {{CHUNK{1'b0}}, b_sh[WIDTH-1:CHUNK]};
            assign res_next = {chunk_d, res_sh[WIDTH-1:CHUNK]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            br     <= 1'b0;
            k      <= '0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        br     <= bin;
                        a_msb  <= a[WIDTH-1];
                        b_msb  <= b[WIDTH-1];
                        res_sh <= '0;
                        k      <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    a_sh   <= a_next;
                    b_sh   <= b_next;
                    res_sh <= res_next;
                    br     <= chain[CHUNK];
                    k      <= k + 1'b1;
                    if (k == KW'(N - 1)) begin
                        // The last chunk finishes here. Publish every flag from
                        // the completed result, so diff never shows a partial value.
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        diff  <= res_next;
                        bout  <= chain[CHUNK];
                        zero  <= (res_next == '0);
                        ovf   <= (a_msb != b_msb) && (res_next[WIDTH-1] != a_msb);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
